scr_arbiter: RTL
================

SCR_ARBITER -- requirements
Module: scr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, scratch RAM address width.
REQ-002 Parameter DATA_W, default 10, scratch RAM data width.
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive locked transfers while the other requester waits (range 1..255).
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 REQ_A, REQ_B  in  1 each  transfer request from port A (MCU core) and port B (DMA/debug).
REQ-007 WE_A, WE_B  in  1 each  1 = write, 0 = read.
REQ-008 LOCK_A, LOCK_B  in  1 each  hold ownership across back-to-back transfers.
REQ-009 ADDR_A, ADDR_B  in  ADDR_W each  transfer address.
REQ-010 WDATA_A, WDATA_B  in  DATA_W each  write data.
REQ-011 GNT_A, GNT_B  out  1 each  port owns the RAM this cycle.
REQ-012 RDATA_A, RDATA_B  out  DATA_W each  registered read data.
REQ-013 RVALID_A, RVALID_B  out  1 each  one-cycle pulse; RDATA valid.
REQ-014 SCR_ADDR  out  ADDR_W  RAM address.
REQ-015 SCR_DATA_IN  out  DATA_W  RAM write data.
REQ-016 SCR_WE  out  1  RAM write enable.
REQ-017 SCR_DATA_OUT  in  DATA_W  RAM asynchronous read data.

Function
REQ-018 States IDLE, OWN_A, OWN_B, registered; GNT_A = (state==OWN_A), GNT_B = (state==OWN_B), never both high.
REQ-019 Transfer on port x occurs at a rising edge where GNT_x and REQ_x are both high; exactly one transfer per such edge.
REQ-020 While OWN_x and REQ_x high, SCR_ADDR/SCR_DATA_IN/SCR_WE shall equal ADDR_x/WDATA_x/WE_x combinationally; otherwise SCR_WE=0, SCR_ADDR=0, SCR_DATA_IN=0.
REQ-021 Read transfer captures SCR_DATA_OUT into RDATA_x at the transfer edge and pulses RVALID_x for the following cycle; RDATA_x holds until the next read on that port.
REQ-022 IDLE: both REQ high -> grant the port not in LAST; only one REQ high -> grant it; none -> stay IDLE.
REQ-023 OWN_x: REQ_x, LOCK_x high and (other REQ low or burst count < MAX_BURST) -> stay OWN_x.
REQ-024 OWN_x otherwise: other REQ high -> switch to other port; else REQ_x high -> stay OWN_x; else -> IDLE.
REQ-025 LAST records the owner of the most recent transfer; updated on every transfer edge.
REQ-026 Burst counter (8 bits) increments on each locked transfer edge while the other REQ is high, clears on any ownership change or entry to IDLE, saturates at MAX_BURST.
REQ-027 Request latency: from IDLE, REQ raised before edge n -> GNT high after edge n -> transfer at edge n+1 -> RVALID high in the cycle after n+1.
REQ-028 REQ_x dropped while GNT_x high: no transfer, SCR_WE=0, ownership released per REQ-024.
REQ-029 Handoff costs no idle cycle: last transfer of A and first GNT_B of B are on consecutive edges.
REQ-030 Requesters shall hold ADDR/WDATA/WE stable while REQ high and not granted; arbiter does not register them.

Reset
REQ-031 RST_N low asynchronously forces state=IDLE, LAST=B, burst count=0, GNT_A=GNT_B=0, RVALID_A=RVALID_B=0, RDATA_A=RDATA_B=0, SCR_WE=0.
REQ-032 Reset asserted mid-transfer: SCR_WE drops immediately, no write or RVALID for that transfer; first grant after release follows REQ-022 with A winning a tie.

Structure
REQ-033 Shared package scr_arb_pkg holds the state enum (IDLE, OWN_A, OWN_B), the owner enum (A, B), and default ADDR_W/DATA_W/MAX_BURST constants.
REQ-034 One sub-module scr_arb_burst_cnt implements the saturating burst counter with clear/increment inputs and a limit-reached output.
REQ-035 RAM is external; the arbiter contains no storage array.

Verification
REQ-036 After reset, REQ_A and REQ_B rise together, both reads -> GNT_A first, then GNT_B on the next cycle (LAST=B at reset).
REQ-037 A writes 0x2A5 to 0x10 and B reads 0x10 on the next grant -> RDATA_B=0x2A5, RVALID_B pulses exactly one cycle.
REQ-038 A holds REQ_A and LOCK_A with REQ_B high, MAX_BURST=8 -> exactly 8 A transfers, then GNT_B; count cleared.
REQ-039 REQ_A alone, LOCK_A low, 5 reads -> GNT_A held continuously, 5 RVALID_A pulses, no idle gaps.
REQ-040 RST_N pulsed low mid-cycle during A write to 0x20 -> SCR_WE low at once, location 0x20 unchanged, all outputs at reset values.
REQ-041 REQ_B dropped while GNT_B high with REQ_A low -> SCR_WE=0, no transfer, state IDLE next cycle.

Source files
------------

// File: rtl/scr_arb_pkg.sv
// Shared types and default sizing for the scratch RAM arbiter.
// Imported by the arbiter top and its burst counter.
package scr_arb_pkg;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 10;
  localparam int unsigned DEF_MAX_BURST = 8;
  localparam int unsigned BURST_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } owner_e;

endpackage

// File: rtl/scr_arb_burst_cnt.sv
// Saturating count of locked transfers made while the other port waits.
// limit_o reports that the transfer happening this cycle is the last one allowed.
module scr_arb_burst_cnt
  import scr_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam logic [BURST_W-1:0] MAX_L = BURST_W'(MAX_BURST);

  logic [BURST_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < MAX_L)) begin
      cnt_d = cnt_q + BURST_W'(1);
    end
  end

  // Looking one transfer ahead lets the owner release on the edge of its last
  // allowed transfer, so the waiting port is granted without a gap.
  always_comb begin
    if (inc_i) begin
      limit_o = (cnt_q >= (MAX_L - BURST_W'(1)));
    end else begin
      limit_o = (cnt_q >= MAX_L);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scr_arbiter.sv
// Two-port arbiter for an external scratch RAM: round-robin on ties, optional
// locked bursts bounded by MAX_BURST, registered read data with a valid pulse.
module scr_arbiter
  import scr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic              WE_A,
  input  logic              WE_B,
  input  logic              LOCK_A,
  input  logic              LOCK_B,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_A,
  input  logic [DATA_W-1:0] WDATA_B,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic [DATA_W-1:0] RDATA_A,
  output logic [DATA_W-1:0] RDATA_B,
  output logic              RVALID_A,
  output logic              RVALID_B,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0] SCR_DATA_IN,
  output logic              SCR_WE,
  input  logic [DATA_W-1:0] SCR_DATA_OUT,
  output arb_state_e        DBG_STATE
);

  arb_state_e        state_q, state_d;
  owner_e            last_q, last_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
  logic              rvalid_a_q, rvalid_b_q;
  logic              xfer_a, xfer_b;
  logic              burst_inc, burst_clr, burst_limit;

  assign xfer_a = (state_q == OWN_A) && REQ_A;
  assign xfer_b = (state_q == OWN_B) && REQ_B;

  // Only locked transfers that keep the other port waiting consume budget.
  assign burst_inc = (xfer_a && LOCK_A && REQ_B) || (xfer_b && LOCK_B && REQ_A);
  assign burst_clr = (state_d != state_q);

  scr_arb_burst_cnt #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (burst_clr),
    .inc_i  (burst_inc),
    .limit_o(burst_limit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (REQ_A && REQ_B) begin
          state_d = (last_q == PORT_A) ? OWN_B : OWN_A;
        end else if (REQ_A) begin
          state_d = OWN_A;
        end else if (REQ_B) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (REQ_A && LOCK_A && (!REQ_B || !burst_limit)) begin
          state_d = OWN_A;
        end else if (REQ_B) begin
          state_d = OWN_B;
        end else if (REQ_A) begin
          state_d = OWN_A;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_B: begin
        if (REQ_B && LOCK_B && (!REQ_A || !burst_limit)) begin
          state_d = OWN_B;
        end else if (REQ_A) begin
          state_d = OWN_A;
        end else if (REQ_B) begin
          state_d = OWN_B;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (xfer_a) begin
      last_d = PORT_A;
    end else if (xfer_b) begin
      last_d = PORT_B;
    end
  end

  // The RAM port is driven straight from the owning requester; idle values are zero.
  always_comb begin
    SCR_ADDR    = '0;
    SCR_DATA_IN = '0;
    SCR_WE      = 1'b0;
    if (xfer_a) begin
      SCR_ADDR    = ADDR_A;
      SCR_DATA_IN = WDATA_A;
      SCR_WE      = WE_A;
    end else if (xfer_b) begin
      SCR_ADDR    = ADDR_B;
      SCR_DATA_IN = WDATA_B;
      SCR_WE      = WE_B;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_q     <= PORT_B;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rvalid_a_q <= xfer_a && !WE_A;
      rvalid_b_q <= xfer_b && !WE_B;
      if (xfer_a && !WE_A) begin
        rdata_a_q <= SCR_DATA_OUT;
      end
      if (xfer_b && !WE_B) begin
        rdata_b_q <= SCR_DATA_OUT;
      end
    end
  end

  assign GNT_A     = (state_q == OWN_A);
  assign GNT_B     = (state_q == OWN_B);
  assign RDATA_A   = rdata_a_q;
  assign RDATA_B   = rdata_b_q;
  assign RVALID_A  = rvalid_a_q;
  assign RVALID_B  = rvalid_b_q;
  assign DBG_STATE = state_q;

endmodule
